ifetch_unit: RTL and testbench

- Instruction-fetch front end for the multicycle MIPS core. It sits upstream of the datapath IR/decode path and owns the architectural PC.
- It runs a request/acknowledge handshake to a variable-latency instruction memory and latches the returned word into IR.
- It signals the control unit when a fresh instruction is valid, and flags a fetch timeout.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/if_timeout_ctr.sv | 34 +++
 rtl/ifetch_unit.sv | 135 +++++++++++++
 tb/tb_ifetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multicycle MIPS core front end.
//   - IF_IDLE / IF_WAIT : instruction-fetch state encodings
//   - RESET_PC_DEFAULT  : byte address loaded into PC on reset
//   - WA_W              : width of a word address (byte address [31:2])
package cpu_pkg;

  localparam logic IF_IDLE = 1'b0;
  localparam logic IF_WAIT = 1'b1;

  typedef enum logic {
    ST_IDLE = IF_IDLE,
    ST_WAIT = IF_WAIT
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          WA_W             = 30;

endpackage

// File: rtl/if_timeout_ctr.sv
// if_timeout_ctr: bounds the time a fetch may spend waiting for memory.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the count (start of a new fetch)
//   en       : one more cycle spent waiting without an acknowledge
//   expire   : high during the TIMEOUT-th waiting cycle (count == TIMEOUT-1 while en)
module if_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // TIMEOUT >= 2, so at least one bit; the count never needs to exceed TIMEOUT-1.
  localparam int             CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end; owns the architectural PC and IR.
//   clk, rst    : clock, asynchronous active-high reset
//   fetch_start : control unit asks for a fetch (looked at only in IDLE)
//   pc_wr, npc  : PC write from the NPC logic, accepted in any state
//   im_req/im_addr/im_ack/im_rdata : instruction memory port
//   ir, ir_valid: instruction register and its one-cycle "updated" pulse
//   fetch_err   : one-cycle pulse when a fetch is abandoned on timeout
//   busy        : high while waiting on memory; it is also the FSM state
//                 (busy=1 <=> IF_WAIT), so state is observable from outside
//   pc, pc_plus4: current PC word address and its successor (wraps)
//
// Memory handshake: im_req rises the cycle after a fetch is launched and is
// held, with im_addr stable, until the fetch ends. The memory returns the word
// by raising im_ack with im_rdata in any cycle im_req is high (including the
// first). The cycle im_ack is seen, im_req drops the next cycle; im_ack
// outside im_req is ignored. An ack in the same cycle the timeout expires
// completes the fetch normally.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_start,
  input  logic            pc_wr,
  input  logic [WA_W-1:0] npc,
  output logic            im_req,
  output logic [WA_W-1:0] im_addr,
  input  logic            im_ack,
  input  logic [31:0]     im_rdata,
  output logic [31:0]     ir,
  output logic            ir_valid,
  output logic            fetch_err,
  output logic            busy,
  output logic [WA_W-1:0] pc,
  output logic [WA_W-1:0] pc_plus4
);

  localparam logic [WA_W-1:0] RESET_WA = RESET_PC[31:2];

  if_state_e state, state_nxt;
  logic      launch;     // IDLE -> WAIT this cycle
  logic      take_ack;   // response accepted this cycle
  logic      ctr_clr;
  logic      ctr_en;
  logic      ctr_expire;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    take_ack  = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_start) begin
          state_nxt = ST_WAIT;
          launch    = 1'b1;
          ctr_clr   = 1'b1;
        end
      end
      ST_WAIT: begin
        // fetch_start is deliberately not looked at here: no queuing.
        if (im_ack) begin
          take_ack  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          ctr_en = 1'b1;
          if (ctr_expire) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  if_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expire (ctr_expire)
  );

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_WA;
      ir        <= '0;
      im_addr   <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      ir_valid  <= take_ack;
      // ctr_expire is only raised when no ack is present, so the pulses are exclusive.
      fetch_err <= ctr_expire;

      // Forward a PC write landing in the launch cycle so the fetch uses it.
      if (launch) begin
        im_addr <= pc_wr ? npc : pc;
      end

      if (take_ack) begin
        ir <= im_rdata;
      end

      // An explicit PC write always beats the post-fetch increment.
      if (pc_wr) begin
        pc <= npc;
      end else if (AUTO_INC && take_ack) begin
        pc <= im_addr + WA_W'(1);
      end
    end
  end

  assign busy     = (state == ST_WAIT);
  assign im_req   = busy;
  assign pc_plus4 = pc + WA_W'(1);

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic        pc_wr;
  logic [29:0] npc;
  logic        im_req;
  logic [29:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        fetch_err;
  logic        busy;
  logic [29:0] pc;
  logic [29:0] pc_plus4;

  int checks   = 0;
  int failures = 0;

  ifetch_unit #(
    .RESET_PC (32'h0000_3000),
    .TIMEOUT  (16),
    .AUTO_INC (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_wr       (pc_wr),
    .npc         (npc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .fetch_err   (fetch_err),
    .busy        (busy),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- directed steps
  initial begin
    rst         = 1'b1;
    fetch_start = 1'b0;
    pc_wr       = 1'b0;
    npc         = '0;
    im_ack      = 1'b0;
    im_rdata    = '0;

    // Reset state
    tick();
    chk("rst_pc",        32'(pc),        32'h0C00);
    chk("rst_pc_plus4",  32'(pc_plus4),  32'h0C01);
    chk("rst_ir",        ir,             32'h0);
    chk("rst_im_req",    32'(im_req),    32'h0);
    chk("rst_im_addr",   32'(im_addr),   32'h0);
    chk("rst_ir_valid",  32'(ir_valid),  32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);

    // 1) zero-wait fetch: fetch_start in cycle 0
    rst         = 1'b0;
    fetch_start = 1'b1;
    tick();                                   // cycle 1
    chk("t1_im_req",   32'(im_req),   32'h1);
    chk("t1_im_addr",  32'(im_addr),  32'h0C00);
    chk("t1_busy",     32'(busy),     32'h1);
    chk("t1_ir_valid0",32'(ir_valid), 32'h0);
    fetch_start = 1'b0;
    im_ack      = 1'b1;
    im_rdata    = 32'h2402_0005;
    tick();                                   // cycle 2
    chk("t1_ir",       ir,            32'h2402_0005);
    chk("t1_ir_valid", 32'(ir_valid), 32'h1);
    chk("t1_im_req0",  32'(im_req),   32'h0);
    chk("t1_busy0",    32'(busy),     32'h0);
    chk("t1_pc",       32'(pc),       32'h0C01);
    chk("t1_pc_plus4", 32'(pc_plus4), 32'h0C02);
    im_ack   = 1'b0;
    im_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t1_ir_valid_end", 32'(ir_valid), 32'h0);
    chk("t1_ir_hold",      ir,            32'h2402_0005);

    // 2) ack after 5 wait cycles: 6 cycles of im_req
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_im_req",   32'(im_req),   32'h1);
      chk("t2_im_addr",  32'(im_addr),  32'h0C01);
      chk("t2_busy",     32'(busy),     32'h1);
      chk("t2_ir_valid0",32'(ir_valid), 32'h0);
      if (i == 5) begin
        im_ack   = 1'b1;
        im_rdata = 32'h8C43_0004;
      end
      tick();
    end
    chk("t2_ir_valid", 32'(ir_valid), 32'h1);
    chk("t2_ir",       ir,            32'h8C43_0004);
    chk("t2_pc",       32'(pc),       32'h0C02);
    chk("t2_im_req0",  32'(im_req),   32'h0);
    im_ack = 1'b0;
    tick();
    chk("t2_ir_valid_end", 32'(ir_valid), 32'h0);

    // 3) no ack: timeout; fetch_start held early in WAIT must be ignored
    fetch_start = 1'b1;
    tick();                                   // im_req rise, cycle 1
    for (int n = 1; n <= 16; n++) begin
      if (n == 4) fetch_start = 1'b0;
      chk("t3_im_req",    32'(im_req),    32'h1);
      chk("t3_fetch_err0",32'(fetch_err), 32'h0);
      chk("t3_im_addr",   32'(im_addr),   32'h0C02);
      tick();
    end
    chk("t3_fetch_err", 32'(fetch_err), 32'h1);
    chk("t3_ir_valid",  32'(ir_valid),  32'h0);
    chk("t3_im_req0",   32'(im_req),    32'h0);
    chk("t3_busy0",     32'(busy),      32'h0);
    chk("t3_ir",        ir,             32'h8C43_0004);
    chk("t3_pc",        32'(pc),        32'h0C02);
    tick();
    chk("t3_fetch_err_end", 32'(fetch_err), 32'h0);

    // 4) pc_wr in the same cycle as fetch_start is forwarded
    fetch_start = 1'b1;
    pc_wr       = 1'b1;
    npc         = 30'h0D00;
    tick();
    chk("t4_im_addr", 32'(im_addr), 32'h0D00);
    chk("t4_pc_wr",   32'(pc),      32'h0D00);
    chk("t4_im_req",  32'(im_req),  32'h1);
    fetch_start = 1'b0;
    pc_wr       = 1'b0;
    im_ack      = 1'b1;
    im_rdata    = 32'h3C01_1234;
    tick();
    chk("t4_pc",       32'(pc),       32'h0D01);
    chk("t4_ir",       ir,            32'h3C01_1234);
    chk("t4_ir_valid", 32'(ir_valid), 32'h1);
    im_ack = 1'b0;
    tick();

    // 5) pc_wr during WAIT, then again on the ack cycle
    fetch_start = 1'b1;
    tick();
    chk("t5_im_addr0", 32'(im_addr), 32'h0D01);
    fetch_start = 1'b0;
    pc_wr       = 1'b1;
    npc         = 30'h0E00;
    tick();
    chk("t5_pc_wr",    32'(pc),      32'h0E00);
    chk("t5_im_addr1", 32'(im_addr), 32'h0D01);
    chk("t5_im_req",   32'(im_req),  32'h1);
    pc_wr = 1'b0;
    tick();
    chk("t5_im_addr2", 32'(im_addr), 32'h0D01);
    chk("t5_pc_hold",  32'(pc),      32'h0E00);
    pc_wr    = 1'b1;
    im_ack   = 1'b1;
    im_rdata = 32'h0000_000C;
    tick();
    chk("t5_pc_wins",  32'(pc),       32'h0E00);
    chk("t5_ir",       ir,            32'h0000_000C);
    chk("t5_ir_valid", 32'(ir_valid), 32'h1);
    pc_wr  = 1'b0;
    im_ack = 1'b0;
    tick();

    // 6) PC wrap on increment
    fetch_start = 1'b1;
    pc_wr       = 1'b1;
    npc         = 30'h3FFF_FFFF;
    tick();
    chk("t6_im_addr",   32'(im_addr),  32'h3FFF_FFFF);
    chk("t6_pc_plus4",  32'(pc_plus4), 32'h0);
    fetch_start = 1'b0;
    pc_wr       = 1'b0;
    im_ack      = 1'b1;
    im_rdata    = 32'h1234_5678;
    tick();
    chk("t6_pc_wrap",   32'(pc),       32'h0);
    chk("t6_ir",        ir,            32'h1234_5678);
    im_ack = 1'b0;
    tick();

    // 7) reset mid-WAIT, then a late ack
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    chk("t7_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t7_im_req_async", 32'(im_req), 32'h0);
    chk("t7_busy_async",   32'(busy),   32'h0);
    chk("t7_pc_async",     32'(pc),     32'h0C00);
    chk("t7_ir_async",     ir,          32'h0);
    tick();
    rst      = 1'b0;
    im_ack   = 1'b1;
    im_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t7_ir_valid", 32'(ir_valid), 32'h0);
    chk("t7_im_req",   32'(im_req),   32'h0);
    chk("t7_pc",       32'(pc),       32'h0C00);
    chk("t7_ir",       ir,            32'h0);
    tick();
    chk("t7_ir_valid2", 32'(ir_valid), 32'h0);
    im_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
